// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_arbiter
//  Purpose  : Serialises each CPU step into an optional data access followed
//             by an instruction fetch on one shared Wishbone-style bus, and
//             holds the CPU paused until both results are latched.
//  Options  : CPU_MEM_ARB_IBUF_EN - one-entry fetch buffer that skips the
//             fetch when the CPU re-requests the last fetched address.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] im_adr_i,
  output logic [31:0] im_dat_o,
  input  logic        dm_en_i,
  input  logic        dm_wr_i,
  input  logic [31:0] dm_adr_i,
  input  logic [3:0]  dm_bytesel_i,
  input  logic [31:0] dm_wdat_i,
  output logic [31:0] dm_rdat_o,
  input  logic        cpu_hold_i,
  output logic        ext_pause_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_DATA  = 2'd1,
    ST_INSTR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter value in the last cycle an access may wait before it is abandoned.
  localparam logic [7:0] c_to_last = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] im_dat_q, im_dat_d;
  logic [31:0] dm_rdat_q, dm_rdat_d;
  logic        err_q, err_d;
  logic        w_expire;

`ifdef CPU_MEM_ARB_IBUF_EN
  logic        ibuf_vld_q, ibuf_vld_d;
  logic [31:0] ibuf_tag_q, ibuf_tag_d;
  logic [31:0] ibuf_dat_q, ibuf_dat_d;
  logic        hit_q, hit_d;
  logic        w_tag_hit;
  logic        w_store_hit;

  assign w_tag_hit   = ibuf_vld_q && (im_adr_i == ibuf_tag_q);
  assign w_store_hit = dm_wr_i && (dm_adr_i[31:2] == ibuf_tag_q[31:2]);
`endif

  // The access gives up when this cycle has no ack and the wait budget is spent.
  assign w_expire = !bus_ack_i && (cnt_q == c_to_last);

  // Next-state, bus drive and result capture for the step sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    im_dat_d    = im_dat_q;
    dm_rdat_d   = dm_rdat_q;
    err_d       = err_q;
    ext_pause_o = 1'b1;
    bus_cyc_o   = 1'b0;
    bus_stb_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_adr_o   = '0;
    bus_sel_o   = '0;
    bus_dat_o   = '0;
`ifdef CPU_MEM_ARB_IBUF_EN
    ibuf_vld_d  = ibuf_vld_q;
    ibuf_tag_d  = ibuf_tag_q;
    ibuf_dat_d  = ibuf_dat_q;
    hit_d       = hit_q;
`endif

    case (state_q)
      ST_START: begin
`ifdef CPU_MEM_ARB_IBUF_EN
        hit_d = w_tag_hit;
        if (dm_en_i) begin
          state_d = ST_DATA;
        end else if (w_tag_hit) begin
          state_d  = ST_DONE;
          im_dat_d = ibuf_dat_q;
        end else begin
          state_d = ST_INSTR;
        end
`else
        state_d = dm_en_i ? ST_DATA : ST_INSTR;
`endif
      end

      ST_DATA: begin
        bus_cyc_o = 1'b1;
        bus_stb_o = 1'b1;
        bus_we_o  = dm_wr_i;
        bus_adr_o = dm_adr_i;
        bus_sel_o = dm_bytesel_i;
        bus_dat_o = dm_wdat_i;
        if (bus_ack_i || w_expire) begin
          if (!dm_wr_i) begin
            dm_rdat_d = bus_ack_i ? bus_dat_i : 32'h0000_0000;
          end
          if (!bus_ack_i) begin
            err_d = 1'b1;
          end
          state_d = ST_INSTR;
`ifdef CPU_MEM_ARB_IBUF_EN
          // A store over the buffered word or a lost access makes the copy stale.
          if (!bus_ack_i || w_store_hit) begin
            ibuf_vld_d = 1'b0;
          end
          if (hit_q && bus_ack_i && !w_store_hit) begin
            state_d  = ST_DONE;
            im_dat_d = ibuf_dat_q;
          end
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_INSTR: begin
        bus_cyc_o = 1'b1;
        bus_stb_o = 1'b1;
        bus_adr_o = im_adr_i;
        bus_sel_o = 4'hF;
        if (bus_ack_i || w_expire) begin
          im_dat_d = bus_ack_i ? bus_dat_i : 32'h0000_0000;
          if (!bus_ack_i) begin
            err_d = 1'b1;
          end
          state_d = ST_DONE;
`ifdef CPU_MEM_ARB_IBUF_EN
          if (bus_ack_i) begin
            ibuf_vld_d = 1'b1;
            ibuf_tag_d = im_adr_i;
            ibuf_dat_d = bus_dat_i;
          end else begin
            ibuf_vld_d = 1'b0;
          end
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        ext_pause_o = 1'b0;
        if (!cpu_hold_i) begin
          state_d = ST_START;
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // State, wait counter and latched results; reset aborts any access at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_START;
      cnt_q     <= '0;
      im_dat_q  <= '0;
      dm_rdat_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      im_dat_q  <= im_dat_d;
      dm_rdat_q <= dm_rdat_d;
      err_q     <= err_d;
    end
  end

`ifdef CPU_MEM_ARB_IBUF_EN
  // Fetch buffer entry and the hit decision taken at the start of the step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ibuf_vld_q <= 1'b0;
      ibuf_tag_q <= '0;
      ibuf_dat_q <= '0;
      hit_q      <= 1'b0;
    end else begin
      ibuf_vld_q <= ibuf_vld_d;
      ibuf_tag_q <= ibuf_tag_d;
      ibuf_dat_q <= ibuf_dat_d;
      hit_q      <= hit_d;
    end
  end
`endif

  assign im_dat_o  = im_dat_q;
  assign dm_rdat_o = dm_rdat_q;
  assign bus_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_mem_arbiter
//  Purpose  : Self-checking bench for cpu_mem_arbiter: a memory-backed bus
//             slave with programmable wait states plus a step-level model of
//             the expected bus traffic, step length and latched results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] im_adr_i = '0;
  logic [31:0] im_dat_o;
  logic        dm_en_i = 1'b0;
  logic        dm_wr_i = 1'b0;
  logic [31:0] dm_adr_i = '0;
  logic [3:0]  dm_bytesel_i = '0;
  logic [31:0] dm_wdat_i = '0;
  logic [31:0] dm_rdat_o;
  logic        cpu_hold_i = 1'b0;
  logic        ext_pause_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_adr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i = '0;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_o;

  cpu_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .im_adr_i     (im_adr_i),
    .im_dat_o     (im_dat_o),
    .dm_en_i      (dm_en_i),
    .dm_wr_i      (dm_wr_i),
    .dm_adr_i     (dm_adr_i),
    .dm_bytesel_i (dm_bytesel_i),
    .dm_wdat_i    (dm_wdat_i),
    .dm_rdat_o    (dm_rdat_o),
    .cpu_hold_i   (cpu_hold_i),
    .ext_pause_o  (ext_pause_o),
    .bus_cyc_o    (bus_cyc_o),
    .bus_stb_o    (bus_stb_o),
    .bus_we_o     (bus_we_o),
    .bus_adr_o    (bus_adr_o),
    .bus_sel_o    (bus_sel_o),
    .bus_dat_o    (bus_dat_o),
    .bus_dat_i    (bus_dat_i),
    .bus_ack_i    (bus_ack_i),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Slave-side memory (written by what the DUT puts on the bus) and the
  // reference memory (written by the model from the intended stimulus).
  logic [31:0] smem [logic [29:0]];
  logic [31:0] rmem [logic [29:0]];

  logic [31:0] exp_im  = '0;
  logic [31:0] exp_dm  = '0;
  logic        exp_err = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        dchk;
    int          wt;
  } acc_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] s_rd(input logic [29:0] w);
    return smem.exists(w) ? smem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] r_rd(input logic [29:0] w);
    return rmem.exists(w) ? rmem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int acc_len(input int w);
    return (w >= TO) ? TO : w + 1;
  endfunction

  // One CPU step. Entered and left at the falling edge inside a START cycle.
  task automatic step(input logic en, input logic wr, input logic [31:0] dadr,
                      input logic [3:0] sel, input logic [31:0] wdat,
                      input logic [31:0] iadr, input int wd, input int wi,
                      input int hold);
    acc_t a;
    acc_t q[$];
    int   exp_len, ncyc, idx, cnt;
    bit   done;

    // Model: expected bus traffic, step length and results.
    exp_len = 2;
    if (en) begin
      a.we = wr; a.adr = dadr; a.sel = sel; a.dat = wdat; a.dchk = 1'b1; a.wt = wd;
      q.push_back(a);
      exp_len += acc_len(wd);
      if (wd >= TO) begin
        exp_err = 1'b1;
        if (!wr) exp_dm = '0;
      end else if (wr) begin
        rmem[dadr[31:2]] = merge(r_rd(dadr[31:2]), wdat, sel);
      end else begin
        exp_dm = r_rd(dadr[31:2]);
      end
    end
    a.we = 1'b0; a.adr = iadr; a.sel = 4'hF; a.dat = '0; a.dchk = 1'b0; a.wt = wi;
    q.push_back(a);
    exp_len += acc_len(wi);
    if (wi >= TO) begin
      exp_err = 1'b1;
      exp_im  = '0;
    end else begin
      exp_im = r_rd(iadr[31:2]);
    end

    // START cycle: no bus activity, CPU paused; stray acks must be ignored.
    chk("start_pause", ext_pause_o, 1'b1);
    chk("start_cyc", bus_cyc_o, 1'b0);
    dm_en_i = en; dm_wr_i = wr; dm_adr_i = dadr; dm_bytesel_i = sel;
    dm_wdat_i = wdat; im_adr_i = iadr; cpu_hold_i = 1'b0;
    bus_ack_i = 1'($urandom_range(0, 1)); bus_dat_i = $urandom;

    ncyc = 1; idx = 0; cnt = 0; done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      ncyc++;
      if (!ext_pause_o) begin
        done = 1'b1;
      end else if (bus_cyc_o) begin
        if (idx < q.size()) begin
          chk("acc_stb", bus_stb_o, 1'b1);
          chk("acc_we", bus_we_o, q[idx].we);
          chk("acc_adr", bus_adr_o, q[idx].adr);
          chk("acc_sel", bus_sel_o, q[idx].sel);
          if (q[idx].dchk) chk("acc_dat", bus_dat_o, q[idx].dat);
          if (cnt == q[idx].wt) begin
            bus_ack_i = 1'b1;
            bus_dat_i = s_rd(bus_adr_o[31:2]);
            if (bus_we_o)
              smem[bus_adr_o[31:2]] = merge(s_rd(bus_adr_o[31:2]), bus_dat_o, bus_sel_o);
          end else begin
            bus_ack_i = 1'b0;
            bus_dat_i = $urandom;
          end
          cnt++;
          if (bus_ack_i || cnt == TO) begin
            idx++;
            cnt = 0;
          end
        end else begin
          chk("extra_access", 32'(idx), 32'(q.size() - 1));
          bus_ack_i = 1'b0;
        end
      end else begin
        chk("cyc_while_paused", bus_cyc_o, 1'b1);
        bus_ack_i = 1'b0;
      end
    end

    chk("step_finished", 32'(done), 32'd1);
    chk("step_len", 32'(ncyc), 32'(exp_len));
    chk("acc_count", 32'(idx), 32'(q.size()));
    chk("done_cyc", bus_cyc_o, 1'b0);
    chk("done_stb", bus_stb_o, 1'b0);
    chk("done_we", bus_we_o, 1'b0);
    chk("done_adr", bus_adr_o, 32'h0);
    chk("done_sel", bus_sel_o, 4'h0);
    chk("done_dat", bus_dat_o, 32'h0);
    chk("im_dat", im_dat_o, exp_im);
    chk("dm_rdat", dm_rdat_o, exp_dm);
    chk("bus_err", bus_err_o, exp_err);

    // DONE: optional CPU hold; nothing may be reissued, results must hold.
    cpu_hold_i = (hold > 0);
    bus_ack_i = 1'($urandom_range(0, 1)); bus_dat_i = $urandom;
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      chk("hold_pause", ext_pause_o, 1'b0);
      chk("hold_cyc", bus_cyc_o, 1'b0);
      chk("hold_im", im_dat_o, exp_im);
      chk("hold_dm", dm_rdat_o, exp_dm);
      bus_ack_i = 1'($urandom_range(0, 1)); bus_dat_i = $urandom;
      if (h == hold) cpu_hold_i = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic int rnd_wait();
    return ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
  endfunction

  task automatic rnd_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           32'h2000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), $urandom,
           32'h2000 + 32'($urandom_range(0, 7)) * 4,
           rnd_wait(), rnd_wait(), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_pause", ext_pause_o, 1'b1);
    chk("rst_cyc", bus_cyc_o, 1'b0);
    chk("rst_stb", bus_stb_o, 1'b0);
    chk("rst_we", bus_we_o, 1'b0);
    chk("rst_adr", bus_adr_o, 32'h0);
    chk("rst_sel", bus_sel_o, 4'h0);
    chk("rst_dat", bus_dat_o, 32'h0);
    chk("rst_im", im_dat_o, 32'h0);
    chk("rst_dm", dm_rdat_o, 32'h0);
    chk("rst_err", bus_err_o, 1'b0);
    reset = 1'b1;

    // Fetch only, zero wait.
    smem[30'h40] = 32'h2402_0005; rmem[30'h40] = 32'h2402_0005;
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h100, 0, 0, 0);

    // Load then fetch, two wait states on each access.
    smem[30'h800] = 32'hCAFE_F00D; rmem[30'h800] = 32'hCAFE_F00D;
    step(1'b1, 1'b0, 32'h2000, 4'hF, 32'h1111_2222, 32'h104, 2, 2, 0);

    // Partial store with the CPU holding DONE for 5 cycles, then read it back.
    step(1'b1, 1'b1, 32'h2004, 4'b0110, 32'hDEAD_BEEF, 32'h108, 1, 0, 5);
    step(1'b1, 1'b0, 32'h2004, 4'hF, 32'h0, 32'h10C, 0, 0, 0);

    // Timeouts on a fetch and on a load; error flag stays set afterwards.
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h110, 0, 99, 0);
    step(1'b1, 1'b0, 32'h2000, 4'hF, 32'h0, 32'h114, 99, 0, 1);

    rnd_steps(40);

    // Reset in the middle of a waiting store.
    dm_en_i = 1'b1; dm_wr_i = 1'b1; dm_adr_i = 32'h2008; dm_bytesel_i = 4'hF;
    dm_wdat_i = 32'h5555_AAAA; im_adr_i = 32'h2000; bus_ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_cyc", bus_cyc_o, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst_cyc", bus_cyc_o, 1'b0);
    chk("arst_stb", bus_stb_o, 1'b0);
    chk("arst_we", bus_we_o, 1'b0);
    chk("arst_pause", ext_pause_o, 1'b1);
    chk("arst_err", bus_err_o, 1'b0);
    chk("arst_im", im_dat_o, 32'h0);
    chk("arst_dm", dm_rdat_o, 32'h0);
    exp_im = '0; exp_dm = '0; exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Fresh zero-wait step after reset, then more random traffic.
    step(1'b1, 1'b0, 32'h2008, 4'hF, 32'h0, 32'h2008, 0, 0, 0);
    rnd_steps(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Single-port memory arbiter between the pipeline CPU's instruction-fetch port and its data port. It serialises each CPU step into at most one data access followed by one instruction fetch on a shared Wishbone-style bus. It holds the CPU's `ext_pause` high until both results are latched. It sits between `pipeline_cpu` (im_*/dm_* ports) and the system memory bus.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles to wait for `bus_ack_i` per access; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `im_adr_i`  in  32  CPU fetch address.
- `im_dat_o`  out  32  fetched instruction to CPU.
- `dm_en_i`  in  1  CPU data access request for this step.
- `dm_wr_i`  in  1  1 = store, 0 = load.
- `dm_adr_i`  in  32  data address.
- `dm_bytesel_i`  in  4  byte lanes.
- `dm_wdat_i`  in  32  store data.
- `dm_rdat_o`  out  32  load data to CPU.
- `cpu_hold_i`  in  1  CPU internal stall (MDU); holds the step open.
- `ext_pause_o`  out  1  to CPU `ext_pause`.
- `bus_cyc_o`, `bus_stb_o`, `bus_we_o`  out  1 each  bus control.
- `bus_adr_o`  out  32  bus address.
- `bus_sel_o`  out  4  byte selects.
- `bus_dat_o`  out  32  write data.
- `bus_dat_i`  in  32  read data.
- `bus_ack_i`  in  1  access complete.
- `bus_err_o`  out  1  sticky timeout flag.

## Operation
- States: START, DATA, INSTR, DONE. The reset state is START.
- START (1 cycle, no bus activity): go to DATA if `dm_en_i`, otherwise go to INSTR.
- DATA:
  - Drive `cyc=stb=1`, `we=dm_wr_i`, `adr=dm_adr_i`, `sel=dm_bytesel_i`, `dat_o=dm_wdat_i`.
  - On ack: for a load, latch `bus_dat_i` into `dm_rdat_o`; then go to INSTR.
- INSTR:
  - Drive `cyc=stb=1`, `we=0`, `adr=im_adr_i`, `sel=4'hF`.
  - On ack: latch `bus_dat_i` into `im_dat_o`; go to DONE.
- DONE:
  - `ext_pause_o=0`, no bus activity, latched outputs held.
  - If `cpu_hold_i=0`, go to START; the CPU advances on this edge.
  - If `cpu_hold_i=1`, stay in DONE. No bus access is repeated, so a store is never issued twice.
- `ext_pause_o=1` in START, DATA and INSTR.
- Bus outputs are all 0 outside DATA and INSTR.
- Timeout:
  - An 8-bit counter clears on entry to DATA or INSTR and increments on each cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES`, the access is abandoned and the next state is taken as if acked.
  - The read value latched on timeout is 32'h0000_0000, and `bus_err_o` is set.
  - `bus_err_o` clears only on reset.
- Reset, including mid-access: state goes to START, the counter goes to 0, and the bus drops immediately (asynchronous). A partially issued access is discarded.

## Timing
- Reset values: `ext_pause_o=1`, all `bus_*_o=0`, `im_dat_o=0`, `dm_rdat_o=0`, `bus_err_o=0`.
- `bus_ack_i` is sampled at the rising edge; ack is earliest in the first cycle of the access, and any ack outside DATA/INSTR is ignored.
- Step length with zero-wait ack:
  - 3 cycles with no data access: START, INSTR, DONE.
  - 4 cycles with a data access: START, DATA, INSTR, DONE.
  - Each wait state adds 1 cycle.
- Back-to-back steps: DONE → START → next access; there is no bus cycle in START.
- Inputs are sampled in START (`dm_en_i`) and throughout DATA/INSTR. The CPU holds them stable while paused.

## Configuration
- `CPU_MEM_ARB_IBUF_EN`: one-entry fetch buffer, holding a tag (32-bit address) and a valid bit.
  - When defined and, in START, buffer valid and `im_adr_i` equals the tag: INSTR is skipped. START goes to DONE (no data access) or DATA goes to DONE, and `im_dat_o` is reloaded from the buffer.
  - The buffer fills on every INSTR ack.
  - Any DATA store whose word address (`adr[31:2]`) matches the tag clears valid. A timeout also clears valid.
  - Reset clears valid.
- When not defined, every step performs INSTR, and no buffer logic or registers exist.

## Test plan
- Fetch only: `dm_en_i=0`, `im_adr_i=0x100`, bus acks with 0x2402_0005 in the first cycle → `ext_pause_o` low in cycle 3 after START, `im_dat_o=0x2402_0005`, exactly one bus read at 0x100.
- Load then fetch: `dm_en_i=1`, `dm_wr_i=0`, `dm_adr_i=0x2000`, ack data 0xCAFE_F00D, 2 wait states on each access → bus order 0x2000 then `im_adr_i`, `dm_rdat_o=0xCAFE_F00D`, pause low on cycle 8.
- Store with `cpu_hold_i` held high 5 cycles in DONE → exactly one `bus_we_o=1` cycle-with-ack at `dm_adr_i` with `sel=dm_bytesel_i`, pause stays low, outputs stable.
- Timeout: `TIMEOUT_CYCLES=4`, no ack → access abandoned after 4 cycles, `im_dat_o=0`, `bus_err_o=1`, which persists until `reset=0`.
- Reset asserted mid-DATA wait → `bus_cyc_o`/`bus_stb_o` drop asynchronously, `ext_pause_o=1`; after release, the sequence restarts from START.
- With `CPU_MEM_ARB_IBUF_EN`:
  - Repeated step at the same `im_adr_i` → no INSTR bus cycle; the step takes 2 cycles (START, DONE).
  - A store to the same word → next step refetches.
